// File: rtl/iagc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// iagc_ctrl_fsm
//   Top-level IAGC control FSM. Decodes single-byte UART commands (plus a
//   big-endian argument for the sample command) and sequences the init,
//   sample and memory-dump engines. The current state code is exported on
//   o_iagc_status for the LED indicator stage.
//
// Ports
//   i_clock         in   system clock, all logic on posedge
//   i_reset         in   synchronous active-high reset
//   i_rx_data       in   received UART byte
//   i_rx_valid      in   1-cycle strobe qualifying i_rx_data
//   i_init_done     in   init sequence finished (level or pulse)
//   i_sample_done   in   sampler finished the requested count
//   i_dump_done     in   memory dump finished
//   o_iagc_status   out  current state code (fixed encoding, see table)
//   o_init_start    out  1-cycle pulse: start init
//   o_sample_start  out  1-cycle pulse: start sampling
//   o_sample_count  out  requested sample count, held until next valid command
//   o_dump_start    out  1-cycle pulse: start memory dump
// -----------------------------------------------------------------------------
//
// state      | meaning
// -----------+----------------------------------------------------------------
// RESET     0| held in reset; leaves on first edge without reset
// INIT      1| init engine running; waits for i_init_done
// IDLE      2| waits for a command byte
// SAMPLE    3| sampler running; waits for i_sample_done
// CMD_PARSE 4| one cycle decoding the latched command byte
// CMD_READ  5| collecting argument bytes, guarded by the inter-byte timeout
// CMD_ERROR 6| one-cycle error indication, back to IDLE
// DUMP_MEM  7| memory dump running; waits for i_dump_done

module iagc_ctrl_fsm #(
    parameter int                    IAGC_STATUS_SIZE  = 4,
    parameter int                    DATA_WIDTH        = 8,
    parameter int                    ARG_BYTES         = 2,
    parameter int                    CMD_TIMEOUT_TICKS = 100000000,
    parameter logic [DATA_WIDTH-1:0] CMD_SAMPLE        = 8'h53,
    parameter logic [DATA_WIDTH-1:0] CMD_DUMP          = 8'h44
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [DATA_WIDTH-1:0]       i_rx_data,
    input  logic                        i_rx_valid,
    input  logic                        i_init_done,
    input  logic                        i_sample_done,
    input  logic                        i_dump_done,
    output logic [IAGC_STATUS_SIZE-1:0] o_iagc_status,
    output logic                        o_init_start,
    output logic                        o_sample_start,
    output logic [8*ARG_BYTES-1:0]      o_sample_count,
    output logic                        o_dump_start
);

    localparam int ARG_WIDTH  = 8 * ARG_BYTES;
    localparam int BYTE_CNT_W = $clog2(ARG_BYTES + 1);
    localparam int TMO_W      = $clog2(CMD_TIMEOUT_TICKS + 1);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(ARG_BYTES - 1);
    localparam logic [TMO_W-1:0]      TMO_LIMIT = TMO_W'(CMD_TIMEOUT_TICKS);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_INIT      = 3'd1,
        ST_IDLE      = 3'd2,
        ST_SAMPLE    = 3'd3,
        ST_CMD_PARSE = 3'd4,
        ST_CMD_READ  = 3'd5,
        ST_CMD_ERROR = 3'd6,
        ST_DUMP_MEM  = 3'd7
    } state_t;

    state_t                  state_q,        state_n;
    logic                    first_q,        first_n;
    logic [DATA_WIDTH-1:0]   cmd_q,          cmd_n;
    logic [ARG_WIDTH-1:0]    arg_q,          arg_n;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q,     byte_cnt_n;
    logic [TMO_W-1:0]        tmo_q,          tmo_n;
    logic [ARG_WIDTH-1:0]    count_q,        count_n;
    logic                    init_start_q,   init_start_n;
    logic                    sample_start_q, sample_start_n;
    logic                    dump_start_q,   dump_start_n;

    logic [TMO_W-1:0]                tmo_inc;
    logic [ARG_WIDTH+DATA_WIDTH-1:0] shift_full;
    logic [ARG_WIDTH-1:0]            arg_shift;

    // MSB-first shift: the oldest byte ends up in the top of the argument.
    assign shift_full = {arg_q, i_rx_data};
    assign arg_shift  = shift_full[ARG_WIDTH-1:0];

    always_comb begin
        state_n        = state_q;
        cmd_n          = cmd_q;
        arg_n          = arg_q;
        byte_cnt_n     = byte_cnt_q;
        tmo_n          = tmo_q;
        count_n        = count_q;
        init_start_n   = 1'b0;
        sample_start_n = 1'b0;
        dump_start_n   = 1'b0;
        // Saturating increment so a stalled counter can never wrap to zero.
        tmo_inc        = (tmo_q == TMO_LIMIT) ? tmo_q : tmo_q + TMO_W'(1);

        case (state_q)
            ST_RESET: begin
                state_n      = ST_INIT;
                init_start_n = 1'b1;
            end

            // first_q masks done inputs in the cycle that carries the start
            // pulse, so a stale done level cannot short-circuit the state.
            ST_INIT: begin
                if (!first_q && i_init_done) begin
                    state_n = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (i_rx_valid) begin
                    cmd_n   = i_rx_data;
                    state_n = ST_CMD_PARSE;
                end
            end

            ST_CMD_PARSE: begin
                byte_cnt_n = '0;
                tmo_n      = '0;
                arg_n      = '0;
                if (cmd_q == CMD_SAMPLE) begin
                    state_n = ST_CMD_READ;
                end else if (cmd_q == CMD_DUMP) begin
                    state_n      = ST_DUMP_MEM;
                    dump_start_n = 1'b1;
                end else begin
                    state_n = ST_CMD_ERROR;
                end
            end

            // A byte takes priority over the timeout: it is checked first, so
            // one arriving in the cycle the counter would hit the limit wins.
            ST_CMD_READ: begin
                if (i_rx_valid) begin
                    arg_n      = arg_shift;
                    tmo_n      = '0;
                    byte_cnt_n = byte_cnt_q + BYTE_CNT_W'(1);
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_n = '0;
                        if (arg_shift == '0) begin
                            state_n = ST_CMD_ERROR;
                        end else begin
                            count_n        = arg_shift;
                            state_n        = ST_SAMPLE;
                            sample_start_n = 1'b1;
                        end
                    end
                end else begin
                    tmo_n = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        state_n = ST_CMD_ERROR;
                    end
                end
            end

            ST_CMD_ERROR: begin
                state_n = ST_IDLE;
            end

            ST_SAMPLE: begin
                if (!first_q && i_sample_done) begin
                    state_n = ST_IDLE;
                end
            end

            ST_DUMP_MEM: begin
                if (!first_q && i_dump_done) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_RESET;
            end
        endcase

        first_n = (state_n != state_q);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q        <= ST_RESET;
            first_q        <= 1'b0;
            cmd_q          <= '0;
            arg_q          <= '0;
            byte_cnt_q     <= '0;
            tmo_q          <= '0;
            count_q        <= '0;
            init_start_q   <= 1'b0;
            sample_start_q <= 1'b0;
            dump_start_q   <= 1'b0;
        end else begin
            state_q        <= state_n;
            first_q        <= first_n;
            cmd_q          <= cmd_n;
            arg_q          <= arg_n;
            byte_cnt_q     <= byte_cnt_n;
            tmo_q          <= tmo_n;
            count_q        <= count_n;
            init_start_q   <= init_start_n;
            sample_start_q <= sample_start_n;
            dump_start_q   <= dump_start_n;
        end
    end

    assign o_iagc_status  = IAGC_STATUS_SIZE'(state_q);
    assign o_init_start   = init_start_q;
    assign o_sample_start = sample_start_q;
    assign o_sample_count = count_q;
    assign o_dump_start   = dump_start_q;

endmodule

// File: tb/tb_iagc_ctrl_fsm.sv
module tb_iagc_ctrl_fsm;

    localparam int TICKS = 20;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        init_done;
    logic        sample_done;
    logic        dump_done;
    logic [3:0]  status;
    logic        init_start;
    logic        sample_start;
    logic [15:0] sample_count;
    logic        dump_start;

    iagc_ctrl_fsm #(
        .IAGC_STATUS_SIZE  (4),
        .DATA_WIDTH        (8),
        .ARG_BYTES         (2),
        .CMD_TIMEOUT_TICKS (TICKS),
        .CMD_SAMPLE        (8'h53),
        .CMD_DUMP          (8'h44)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .i_init_done    (init_done),
        .i_sample_done  (sample_done),
        .i_dump_done    (dump_done),
        .o_iagc_status  (status),
        .o_init_start   (init_start),
        .o_sample_start (sample_start),
        .o_sample_count (sample_count),
        .o_dump_start   (dump_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record = inputs driven for one cycle + outputs expected after that edge.
    typedef struct {
        logic        rst;
        logic        rxv;
        logic [7:0]  rxd;
        logic        ini;
        logic        sd;
        logic        dd;
        logic [3:0]  st;
        logic        ist;
        logic        sst;
        logic        dst;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_no = 0;

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic ini, input logic sd, input logic dd,
                                input logic [3:0] st, input logic ist, input logic sst,
                                input logic dst, input logic [15:0] cnt);
        vec_t t;
        t.rst = r; t.rxv = v; t.rxd = d; t.ini = ini; t.sd = sd; t.dd = dd;
        t.st = st; t.ist = ist; t.sst = sst; t.dst = dst; t.cnt = cnt;
        return t;
    endfunction

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, step_no, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard step %0d: got empty queue, expected an entry", step_no);
            return;
        end
        e = exp_q.pop_front();
        cmp("status",       16'(status),       16'(e.st));
        cmp("init_start",   16'(init_start),   16'(e.ist));
        cmp("sample_start", 16'(sample_start), 16'(e.sst));
        cmp("dump_start",   16'(dump_start),   16'(e.dst));
        cmp("sample_count", sample_count,      e.cnt);
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst         = v.rst;
        rx_valid    = v.rxv;
        rx_data     = v.rxd;
        init_done   = v.ini;
        sample_done = v.sd;
        dump_done   = v.dd;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        step_no++;
        check_out();
    endtask

    // Idle cycle with no inputs, expecting the given status and count.
    task automatic nop(input logic [3:0] st, input logic [15:0] cnt);
        step(mk(0, 0, 8'h00, 0, 0, 0, st, 0, 0, 0, cnt));
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        init_done = 1'b0; sample_done = 1'b0; dump_done = 1'b0;

        //              rst rxv rxd    ini sd dd  st ist sst dst cnt
        // reset and init (done in first INIT cycle must be ignored)
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 2, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 2, 0, 0, 0, 16'h0000));
        // sample 0x0010; byte during CMD_PARSE and during SAMPLE dropped
        tbl.push_back(mk(0, 1, 8'h53, 0, 0, 0, 4, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 1, 8'h44, 0, 0, 0, 5, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 5, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 1, 8'h10, 0, 0, 0, 3, 0, 1, 0, 16'h0010));
        tbl.push_back(mk(0, 1, 8'h44, 0, 1, 0, 3, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 3, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 2, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 2, 0, 0, 0, 16'h0010));
        // dump; done in first DUMP cycle ignored, taken the next cycle
        tbl.push_back(mk(0, 1, 8'h44, 0, 0, 0, 4, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 7, 0, 0, 1, 16'h0010));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 7, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 2, 0, 0, 0, 16'h0010));
        // unknown opcode; bytes in CMD_PARSE/CMD_ERROR dropped
        tbl.push_back(mk(0, 1, 8'h58, 0, 0, 0, 4, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 1, 8'h53, 0, 0, 0, 6, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 1, 8'h53, 0, 0, 0, 2, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 2, 0, 0, 0, 16'h0010));
        // zero count is an error, count kept
        tbl.push_back(mk(0, 1, 8'h53, 0, 0, 0, 4, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 5, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 5, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 6, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 2, 0, 0, 0, 16'h0010));
        // sample 0x0102, reset mid-SAMPLE aborts and clears count
        tbl.push_back(mk(0, 1, 8'h53, 0, 0, 0, 4, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 5, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 1, 8'h01, 0, 0, 0, 5, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 1, 8'h02, 0, 0, 0, 3, 0, 1, 0, 16'h0102));
        tbl.push_back(mk(0, 1, 8'h44, 0, 0, 0, 3, 0, 0, 0, 16'h0102));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 16'h0000));

        foreach (tbl[i]) step(tbl[i]);

        // back to IDLE
        nop(1, 16'h0000);
        step(mk(0, 0, 8'h00, 1, 0, 0, 2, 0, 0, 0, 16'h0000));

        // inter-byte timeout: 20 silent cycles after the first arg byte
        step(mk(0, 1, 8'h53, 0, 0, 0, 4, 0, 0, 0, 16'h0000));
        nop(5, 16'h0000);
        step(mk(0, 1, 8'h00, 0, 0, 0, 5, 0, 0, 0, 16'h0000));
        for (int i = 1; i < TICKS; i++) nop(5, 16'h0000);
        nop(6, 16'h0000);
        nop(2, 16'h0000);

        // byte arriving in the cycle the timeout would fire wins
        step(mk(0, 1, 8'h53, 0, 0, 0, 4, 0, 0, 0, 16'h0000));
        nop(5, 16'h0000);
        step(mk(0, 1, 8'h00, 0, 0, 0, 5, 0, 0, 0, 16'h0000));
        for (int i = 1; i < TICKS; i++) nop(5, 16'h0000);
        step(mk(0, 1, 8'h05, 0, 0, 0, 3, 0, 1, 0, 16'h0005));
        step(mk(0, 0, 8'h00, 0, 1, 0, 3, 0, 0, 0, 16'h0005));
        step(mk(0, 0, 8'h00, 0, 1, 0, 2, 0, 0, 0, 16'h0005));

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
